// File: rtl/i2c_slave_responder.sv
// I2C slave that accepts writes as a strobed byte stream and answers reads from a host-loaded buffer.
// SCL/SDA are synchronised into clk_i; all bus decisions use the synchronised copies.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h22,
    parameter int         DATA_WIDTH = 8,
    parameter int         BUF_DEPTH  = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         scl_i,
    input  logic                         sda_i,
    output logic                         sda_o,
    input  logic                         load_en_i,
    input  logic [$clog2(BUF_DEPTH)-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0]        load_data_i,
    output logic                         wr_strobe_o,
    output logic [DATA_WIDTH-1:0]        wr_data_o,
    output logic                         busy_o
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int SW = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0] ADDR_BITS = CW'(8);
    localparam logic [CW-1:0] DATA_BITS = CW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t                state, state_n;
    logic                  scl_meta, scl_sync, scl_prev;
    logic                  sda_meta, sda_sync, sda_prev;
    logic                  scl_rise, scl_fall, start_det, stop_det;
    logic [CW-1:0]         bit_cnt, bit_cnt_n;
    logic [SW-1:0]         shift_r, shift_n;
    logic [DATA_WIDTH-1:0] tx_r, tx_n;
    logic [AW-1:0]         rd_ptr, rd_ptr_n;
    logic                  sda_n, wr_strobe_n;
    logic [DATA_WIDTH-1:0] wr_data_n;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= scl_i;
            scl_sync <= scl_meta;
            scl_prev <= scl_sync;
            sda_meta <= sda_i;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    // START/STOP require SCL high on both samples so SCL edges never alias into bus conditions
    assign scl_rise  = scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync & scl_prev;
    assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_r     <= '0;
            tx_r        <= '0;
            rd_ptr      <= '0;
            sda_o       <= 1'b1;
            wr_strobe_o <= 1'b0;
            wr_data_o   <= '0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift_r     <= shift_n;
            tx_r        <= tx_n;
            rd_ptr      <= rd_ptr_n;
            sda_o       <= sda_n;
            wr_strobe_o <= wr_strobe_n;
            wr_data_o   <= wr_data_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_r;
        tx_n        = tx_r;
        rd_ptr_n    = rd_ptr;
        sda_n       = sda_o;
        wr_strobe_n = 1'b0;
        wr_data_n   = wr_data_o;
        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_n     = 1'b1;
        end else if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_n     = 1'b1;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = {shift_r[SW-2:0], sda_sync};
                        bit_cnt_n = bit_cnt + CW'(1);
                    end else if (scl_fall && bit_cnt == ADDR_BITS) begin
                        bit_cnt_n = '0;
                        if (shift_r[7:1] == SLAVE_ADDR) begin
                            state_n = ADDR_ACK;
                            sda_n   = 1'b0;
                        end else begin
                            state_n = IGNORE;
                            sda_n   = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    // shift_r[0] still holds the R/W bit here
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (shift_r[0]) begin
                            state_n = RD_DATA;
                            tx_n    = mem[rd_ptr];
                            sda_n   = tx_n[DATA_WIDTH-1];
                        end else begin
                            state_n = WR_DATA;
                            sda_n   = 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_n   = {shift_r[SW-2:0], sda_sync};
                        bit_cnt_n = bit_cnt + CW'(1);
                        if (bit_cnt_n == DATA_BITS) begin
                            wr_strobe_n = 1'b1;
                            wr_data_n   = shift_n[DATA_WIDTH-1:0];
                        end
                    end else if (scl_fall && bit_cnt == DATA_BITS) begin
                        state_n   = WR_ACK;
                        bit_cnt_n = '0;
                        sda_n     = 1'b0;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_n = WR_DATA;
                        sda_n   = 1'b1;
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + CW'(1);
                    end else if (scl_fall) begin
                        if (bit_cnt == DATA_BITS) begin
                            state_n   = RD_ACK;
                            bit_cnt_n = '0;
                            sda_n     = 1'b1;
                        end else begin
                            tx_n  = tx_r << 1;
                            sda_n = tx_n[DATA_WIDTH-1];
                        end
                    end
                end
                RD_ACK: begin
                    // bit_cnt==1 marks a master ACK awaiting the next falling edge
                    if (scl_rise) begin
                        rd_ptr_n = rd_ptr + AW'(1);
                        if (sda_sync) begin
                            state_n = IGNORE;
                        end else begin
                            bit_cnt_n = CW'(1);
                        end
                    end else if (scl_fall && bit_cnt == CW'(1)) begin
                        state_n   = RD_DATA;
                        bit_cnt_n = '0;
                        tx_n      = mem[rd_ptr];
                        sda_n     = tx_n[DATA_WIDTH-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o = (state != IDLE) && (state != IGNORE);

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Randomised bench: an I2C master drives the responder and a buffer/pointer model predicts every byte.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

    localparam int DEPTH = 64;
    localparam int Q = 80;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       load_en_i = 1'b0;
    logic [5:0] load_addr_i = '0;
    logic [7:0] load_data_i = '0;
    logic       sda_o, wr_strobe_o, busy_o;
    logic [7:0] wr_data_o;
    logic       sda_bus;

    assign sda_bus = sda_m & sda_o;

    i2c_slave_responder #(.SLAVE_ADDR(7'h22), .DATA_WIDTH(8), .BUF_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_o),
        .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
        .wr_strobe_o(wr_strobe_o), .wr_data_o(wr_data_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] model_mem [DEPTH];
    int         model_ptr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always @(negedge clk_i) if (wr_strobe_o) got_q.push_back(wr_data_o);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic busStart();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic busStop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic sendBit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic recvBit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = sda_bus; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic sendByte(input logic [7:0] v, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) sendBit(v[i]);
        recvBit(b);
        acked = ~b;
    endtask

    task automatic loadBuf(input logic [5:0] idx, input logic [7:0] val);
        @(negedge clk_i);
        load_en_i = 1'b1; load_addr_i = idx; load_data_i = val;
        @(negedge clk_i);
        load_en_i = 1'b0;
        model_mem[idx] = val;
    endtask

    task automatic recvByte(input logic ack, input logic mid_load, input logic [5:0] idx,
                            input logic [7:0] ld_val, output logic [7:0] d);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            recvBit(b);
            d = {d[6:0], b};
            if (mid_load && i == 2) loadBuf(idx, ld_val);
        end
        sendBit(~ack);
    endtask

    // Reads n bytes from the model pointer, ACKing all but the last
    task automatic readTransfer(input int n, input logic mid_load);
        logic       acked;
        logic [7:0] d, e;
        busStart();
        sendByte(8'h45, acked);
        checkOutput("rd_addr_ack", acked, 1);
        for (int i = 0; i < n; i++) begin
            e = model_mem[model_ptr];
            recvByte(i != n - 1, mid_load && i == 0, 6'(model_ptr), 8'($urandom), d);
            checkOutput("rd_data", d, e);
            model_ptr = (model_ptr + 1) % DEPTH;
        end
        busStop();
    endtask

    task automatic writeTransfer(input int n, input logic random_data);
        logic       acked;
        logic [7:0] v;
        busStart();
        sendByte(8'h44, acked);
        checkOutput("wr_addr_ack", acked, 1);
        checkOutput("busy_addressed", busy_o, 1);
        for (int i = 0; i < n; i++) begin
            v = random_data ? 8'($urandom) : 8'(i);
            sendByte(v, acked);
            checkOutput("wr_data_ack", acked, 1);
            exp_q.push_back(v);
        end
        busStop();
        repeat (4) @(posedge clk_i);
        #1 checkOutput("busy_after_stop", busy_o, 0);
    endtask

    task automatic checkWrites();
        checkOutput("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            checkOutput("wr_data", got_q[i], exp_q[i]);
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic applyStimulus(input int iter);
        int nrd;
        writeTransfer($urandom_range(1, 6), 1'b1);
        checkWrites();
        for (int i = 0; i < 3; i++) loadBuf(6'($urandom), 8'($urandom));
        nrd = $urandom_range(1, 5);
        readTransfer(nrd, iter[0]);
    endtask

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic       acked;
        logic [7:0] d, e;

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_sda", sda_o, 1);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_strobe", wr_strobe_o, 0);
        checkOutput("rst_wr_data", wr_data_o, 0);
        @(negedge clk_i) rst_i = 1'b0;
        repeat (4) @(posedge clk_i);

        // 32 sequential writes
        writeTransfer(32, 1'b0);
        checkWrites();

        // preload 100+i then 32 reads
        for (int i = 0; i < DEPTH; i++) loadBuf(6'(i), 8'(100 + i));
        readTransfer(32, 1'b0);

        // foreign address is NACKed and ignored
        busStart();
        sendByte(8'h88, acked);
        checkOutput("foreign_nack", acked, 0);
        checkOutput("foreign_busy", busy_o, 0);
        sendByte(8'hAA, acked);
        checkOutput("foreign_data_nack", acked, 0);
        busStop();
        checkWrites();

        // advance pointer to 63, then write + repeated START read across the wrap
        readTransfer(31, 1'b0);
        busStart();
        sendByte(8'h44, acked);
        checkOutput("rs_addr_ack", acked, 1);
        sendByte(8'h05, acked);
        checkOutput("rs_data_ack", acked, 1);
        exp_q.push_back(8'h05);
        busStart();
        sendByte(8'h45, acked);
        checkOutput("rs_rd_ack", acked, 1);
        e = model_mem[model_ptr];
        checkOutput("rs_ptr_is_63", model_ptr, 63);
        recvByte(1'b0, 1'b0, '0, '0, d);
        checkOutput("rs_rd_data", d, e);
        model_ptr = (model_ptr + 1) % DEPTH;
        busStop();
        readTransfer(1, 1'b0);
        checkWrites();
        checkOutput("wr_data_held", wr_data_o, 8'h05);

        // STOP after 4 data bits aborts the byte
        busStart();
        sendByte(8'h44, acked);
        checkOutput("abort_addr_ack", acked, 1);
        for (int i = 0; i < 4; i++) sendBit(1'($urandom));
        busStop();
        repeat (4) @(posedge clk_i);
        #1 checkOutput("abort_busy", busy_o, 0);
        checkWrites();

        for (int it = 0; it < 4; it++) applyStimulus(it);

        // reset while the address ACK is being driven
        busStart();
        for (int i = 7; i >= 0; i--) sendBit(((8'h45 >> i) & 1) != 0);
        checkOutput("ack_driven", sda_o, 0);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 checkOutput("rst_async_release", sda_o, 1);
        checkOutput("rst_busy_mid", busy_o, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        model_ptr = 0;
        repeat (4) @(posedge clk_i);
        readTransfer(1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
